// File: rtl/mem_port_arb_pkg.sv
// Shared types and constants for the IF/M memory port arbiter.
package mem_port_arb_pkg;

  localparam int unsigned RegW  = 64;
  localparam int unsigned InstW = 32;
  localparam int unsigned MaskW = 8;
  localparam int unsigned CntW  = 8;

  localparam logic [RegW-1:0] ZeroWord = '0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StResp = 2'd2,
    StDone = 2'd3
  } arb_state_e;

  typedef enum logic {
    OwnIf = 1'b0,
    OwnM  = 1'b1
  } owner_e;

  // Pick the 32-bit instruction half of a 64-bit bus word.
  function automatic logic [InstW-1:0] sel_inst(input logic [RegW-1:0] word, input logic hi);
    return hi ? word[63:32] : word[31:0];
  endfunction

endpackage

// File: rtl/mem_port_arb.sv
// Single shared memory port sequencer for instruction fetch and the memory stage.
// One transaction in flight; M has priority over IF; watchdog bounds the response wait.
module mem_port_arb
  import mem_port_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [RegW-1:0]  if_addr,
  output logic             if_done,
  output logic [InstW-1:0] if_rdata,
  output logic             if_err,
  input  logic             m_req,
  input  logic             m_we,
  input  logic [RegW-1:0]  m_addr,
  input  logic [RegW-1:0]  m_wdata,
  input  logic [MaskW-1:0] m_wmask,
  output logic             m_done,
  output logic [RegW-1:0]  m_rdata,
  output logic             m_err,
  output logic             stall_if,
  output logic             stall_m,
  output logic             bus_valid,
  input  logic             bus_ready,
  output logic             bus_we,
  output logic [RegW-1:0]  bus_addr,
  output logic [RegW-1:0]  bus_wdata,
  output logic [MaskW-1:0] bus_wmask,
  input  logic             bus_resp_valid,
  input  logic [RegW-1:0]  bus_rdata
);

  localparam bit             WdogEn      = (TIMEOUT != 0);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT - 1);

  arb_state_e       state_q, state_d;
  owner_e           owner_q, owner_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             bus_valid_q, bus_valid_d;
  logic             bus_we_q, bus_we_d;
  logic [RegW-1:0]  bus_addr_q, bus_addr_d;
  logic [RegW-1:0]  bus_wdata_q, bus_wdata_d;
  logic [MaskW-1:0] bus_wmask_q, bus_wmask_d;
  logic             if_done_q, if_done_d;
  logic             m_done_q, m_done_d;
  logic [InstW-1:0] if_rdata_q, if_rdata_d;
  logic [RegW-1:0]  m_rdata_q, m_rdata_d;
  logic             if_err_q, if_err_d;
  logic             m_err_q, m_err_d;
  logic             wdog_fire;

  assign wdog_fire = WdogEn && (cnt_q == TimeoutLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (m_req || if_req) state_d = StReq;
      StReq:  if (bus_ready) state_d = StResp;
      StResp: if (bus_resp_valid || wdog_fire) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state; done pulses are registered so they line up with StDone.
  always_comb begin
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    bus_valid_d = bus_valid_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wmask_d = bus_wmask_q;
    if_done_d   = 1'b0;
    m_done_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    m_rdata_d   = m_rdata_q;
    if_err_d    = if_err_q;
    m_err_d     = m_err_q;
    unique case (state_q)
      StIdle: begin
        if (m_req) begin
          owner_d     = OwnM;
          bus_valid_d = 1'b1;
          bus_we_d    = m_we;
          bus_addr_d  = m_addr;
          bus_wdata_d = m_wdata;
          bus_wmask_d = m_wmask;
        end else if (if_req) begin
          owner_d     = OwnIf;
          bus_valid_d = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = if_addr;
          bus_wdata_d = ZeroWord;
          bus_wmask_d = '0;
        end
      end
      StReq: begin
        if (bus_ready) begin
          bus_valid_d = 1'b0;
          cnt_d       = '0;
        end
      end
      StResp: begin
        if (bus_resp_valid) begin
          if (owner_q == OwnM) begin
            m_rdata_d = bus_we_q ? ZeroWord : bus_rdata;
            m_err_d   = 1'b0;
            m_done_d  = 1'b1;
          end else begin
            if_rdata_d = sel_inst(bus_rdata, bus_addr_q[2]);
            if_err_d   = 1'b0;
            if_done_d  = 1'b1;
          end
        end else if (wdog_fire) begin
          if (owner_q == OwnM) begin
            m_rdata_d = ZeroWord;
            m_err_d   = 1'b1;
            m_done_d  = 1'b1;
          end else begin
            if_rdata_d = '0;
            if_err_d   = 1'b1;
            if_done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q     <= OwnIf;
      cnt_q       <= '0;
      bus_valid_q <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wmask_q <= '0;
      if_done_q   <= 1'b0;
      m_done_q    <= 1'b0;
      if_rdata_q  <= '0;
      m_rdata_q   <= '0;
      if_err_q    <= 1'b0;
      m_err_q     <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      bus_valid_q <= bus_valid_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wmask_q <= bus_wmask_d;
      if_done_q   <= if_done_d;
      m_done_q    <= m_done_d;
      if_rdata_q  <= if_rdata_d;
      m_rdata_q   <= m_rdata_d;
      if_err_q    <= if_err_d;
      m_err_q     <= m_err_d;
    end
  end

  assign bus_valid = bus_valid_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_wmask = bus_wmask_q;
  assign if_done   = if_done_q;
  assign m_done    = m_done_q;
  assign if_rdata  = if_rdata_q;
  assign m_rdata   = m_rdata_q;
  assign if_err    = if_err_q;
  assign m_err     = m_err_q;
  assign stall_if  = if_req & ~if_done_q;
  assign stall_m   = m_req & ~m_done_q;

endmodule

// File: tb/tb_mem_port_arb.sv
// Self-checking bench for mem_port_arb: vector table plus hand-written corner sequences.
module tb_mem_port_arb;

  localparam int unsigned TbTimeout = 4;

  typedef struct {
    logic        is_m;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] rdata;
    int          ready_wait;
    int          resp_wait;
    bit          noresp;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic        is_m;
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  logic        clk, rst;
  logic        if_req, m_req, m_we;
  logic [63:0] if_addr, m_addr, m_wdata, bus_rdata;
  logic [7:0]  m_wmask;
  logic        bus_ready, bus_resp_valid;
  logic        if_done, if_err, m_done, m_err, stall_if, stall_m;
  logic [31:0] if_rdata;
  logic [63:0] m_rdata;
  logic        bus_valid, bus_we;
  logic [63:0] bus_addr, bus_wdata;
  logic [7:0]  bus_wmask;

  // Second instance with the watchdog disabled.
  logic        z_if_req, z_m_req, z_resp;
  logic        z_if_done, z_if_err, z_m_done, z_m_err, z_stall_if, z_stall_m;
  logic [31:0] z_if_rdata;
  logic [63:0] z_m_rdata, z_bus_addr, z_bus_wdata;
  logic        z_bus_valid, z_bus_we;
  logic [7:0]  z_bus_wmask;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  vec_t vecs[7];

  mem_port_arb #(.TIMEOUT(TbTimeout)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_err(if_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wmask(m_wmask),
    .m_done(m_done), .m_rdata(m_rdata), .m_err(m_err),
    .stall_if(stall_if), .stall_m(stall_m),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
    .bus_resp_valid(bus_resp_valid), .bus_rdata(bus_rdata)
  );

  mem_port_arb #(.TIMEOUT(0)) dut_nowd (
    .clk(clk), .rst(rst),
    .if_req(z_if_req), .if_addr(if_addr), .if_done(z_if_done), .if_rdata(z_if_rdata),
    .if_err(z_if_err),
    .m_req(z_m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wmask(m_wmask),
    .m_done(z_m_done), .m_rdata(z_m_rdata), .m_err(z_m_err),
    .stall_if(z_stall_if), .stall_m(z_stall_m),
    .bus_valid(z_bus_valid), .bus_ready(bus_ready), .bus_we(z_bus_we), .bus_addr(z_bus_addr),
    .bus_wdata(z_bus_wdata), .bus_wmask(z_bus_wmask),
    .bus_resp_valid(z_resp), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and score any completed transaction.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (if_done || m_done) begin
      chk("done_exclusive", 64'(if_done & m_done), 64'd0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=%0b%0b required=00", if_done, m_done);
      end else begin
        e = sb.pop_front();
        chk("done_owner", 64'(m_done), 64'(e.is_m));
        chk("done_rdata", m_done ? m_rdata : 64'(if_rdata), e.rdata);
        chk("done_err", 64'(m_done ? m_err : if_err), 64'(e.err));
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   lat;
    bit   seen;
    int   exp_lat;
    e.is_m  = v.is_m;
    e.rdata = v.exp_rdata;
    e.err   = v.exp_err;
    sb.push_back(e);
    bus_rdata = v.rdata;
    bus_ready = 1'b0;
    bus_resp_valid = 1'b0;
    if (v.is_m) begin
      m_req = 1'b1; m_we = v.we; m_addr = v.addr; m_wdata = v.wdata; m_wmask = v.wmask;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    #1;
    chk("stall_start", 64'(v.is_m ? stall_m : stall_if), 64'd1);
    tick();
    for (int i = 0; i <= v.ready_wait; i++) begin
      chk("req_valid", 64'(bus_valid), 64'd1);
      chk("req_addr", bus_addr, v.addr);
      chk("req_we", 64'(bus_we), 64'(v.is_m ? v.we : 1'b0));
      chk("req_wmask", 64'(bus_wmask), 64'(v.is_m ? v.wmask : 8'h00));
      if (v.is_m) chk("req_wdata", bus_wdata, v.wdata);
      chk("req_stall", 64'(v.is_m ? stall_m : stall_if), 64'd1);
      bus_ready = (i == v.ready_wait);
      tick();
    end
    bus_ready = 1'b0;
    chk("resp_valid_low", 64'(bus_valid), 64'd0);
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      bus_resp_valid = !v.noresp && (lat == v.resp_wait);
      tick();
      lat++;
      seen = if_done || m_done;
    end
    bus_resp_valid = 1'b0;
    exp_lat = v.noresp ? TbTimeout : v.resp_wait + 1;
    chk("done_latency", 64'(lat), 64'(exp_lat));
    chk("stall_at_done", 64'(v.is_m ? stall_m : stall_if), 64'd0);
    if (v.is_m) m_req = 1'b0; else if_req = 1'b0;
    tick();
    chk("rdata_hold", v.is_m ? m_rdata : 64'(if_rdata), v.exp_rdata);
    chk("idle_valid", 64'(bus_valid), 64'd0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 64'h8000_0004, 64'h0, 8'h00, 64'h1111_2222_3333_4444, 0, 0, 1'b0,
                64'h1111_2222, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 64'h8000_0008, 64'h0, 8'h00, 64'hAAAA_BBBB_CCCC_DDDD, 0, 1, 1'b0,
                64'hCCCC_DDDD, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 64'h0000_1000, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF, 1, 2, 1'b0,
                64'h0123_4567_89AB_CDEF, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 64'h0000_2008, 64'hDEAD_BEEF, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 3, 0,
                1'b0, 64'h0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 64'h0000_3000, 64'h0, 8'h00, 64'h5A5A_5A5A_5A5A_5A5A, 0, 0, 1'b1,
                64'h0, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 64'h8000_000C, 64'h0, 8'h00, 64'h9999_8888_7777_6666, 0, 3, 1'b0,
                64'h9999_8888, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 64'h0000_3008, 64'h0, 8'h00, 64'h0BAD_F00D_CAFE_0001, 2, 3, 1'b0,
                64'h0BAD_F00D_CAFE_0001, 1'b0};

    rst = 1'b1;
    if_req = 1'b0; m_req = 1'b0; m_we = 1'b0;
    if_addr = '0; m_addr = '0; m_wdata = '0; m_wmask = '0;
    bus_ready = 1'b0; bus_resp_valid = 1'b0; bus_rdata = '0;
    z_if_req = 1'b0; z_m_req = 1'b0; z_resp = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_bus_valid", 64'(bus_valid), 64'd0);
    chk("rst_bus_addr", bus_addr, 64'd0);
    chk("rst_bus_fields", {bus_wdata[55:0], bus_wmask}, 64'd0);
    chk("rst_dones", 64'({if_done, m_done, if_err, m_err, bus_we}), 64'd0);
    chk("rst_rdata", m_rdata | 64'(if_rdata), 64'd0);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // M and IF together: M first, idle DONE cycle, then IF.
    bus_rdata = 64'h5555_6666_7777_8888;
    m_req = 1'b1; m_we = 1'b0; m_addr = 64'h0000_4000;
    if_req = 1'b1; if_addr = 64'h8000_0010;
    sb.push_back('{1'b1, 64'h5555_6666_7777_8888, 1'b0});
    sb.push_back('{1'b0, 64'h7777_8888, 1'b0});
    tick();
    chk("prio_addr_m", bus_addr, 64'h0000_4000);
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0; bus_resp_valid = 1'b1;
    tick();
    bus_resp_valid = 1'b0;
    chk("prio_m_done", 64'({m_done, if_done}), 64'b10);
    m_req = 1'b0;
    tick();
    chk("prio_no_dup_grant", 64'(bus_valid), 64'd0);
    tick();
    chk("prio_if_valid", 64'(bus_valid), 64'd1);
    chk("prio_addr_if", bus_addr, 64'h8000_0010);
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0; bus_resp_valid = 1'b1;
    tick();
    bus_resp_valid = 1'b0;
    chk("prio_if_done", 64'({m_done, if_done}), 64'b01);
    if_req = 1'b0;
    tick();
    chk("prio_sb_empty", 64'(sb.size()), 64'd0);

    // Watchdog disabled: the second instance must wait in RESP indefinitely.
    begin
      int early;
      early = 0;
      m_addr = 64'h0000_5000; m_we = 1'b0;
      z_m_req = 1'b1;
      tick();
      chk("nowd_req_valid", 64'(z_bus_valid), 64'd1);
      bus_ready = 1'b1;
      tick();
      bus_ready = 1'b0;
      for (int i = 0; i < 300; i++) begin
        tick();
        if (z_m_done) early++;
      end
      chk("nowd_no_done", 64'(early), 64'd0);
      chk("nowd_stall", 64'({z_stall_m, z_bus_valid}), 64'b10);
      z_m_req = 1'b0;
    end

    // Asynchronous reset while in REQ, then a held if_req is served again.
    if_req = 1'b1; if_addr = 64'h8000_0020;
    tick();
    chk("arst_pre_valid", 64'(bus_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(bus_valid), 64'd0);
    chk("arst_addr", bus_addr, 64'd0);
    chk("arst_rdata", m_rdata | 64'(if_rdata), 64'd0);
    chk("arst_flags", 64'({if_done, m_done, if_err, m_err}), 64'd0);
    tick();
    rst = 1'b0;
    run_vec('{1'b0, 1'b0, 64'h8000_0020, 64'h0, 8'h00, 64'h1234_5678_9ABC_DEF0, 0, 0, 1'b0,
              64'h9ABC_DEF0, 1'b0});
    chk("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arb.md
Name: mem_port_arb

Overview:
- Sequences the single shared memory port between instruction fetch (IF) and the memory stage (M, loads/stores).
- One outstanding transaction at a time; FSM with registered request and response handshake.
- Generates per-requester done pulses and stall signals for the pipeline.
- Response watchdog returns an error instead of hanging the core.

Parameters:
- TIMEOUT, 255, max cycles waited in RESP for bus_resp_valid; 0 disables watchdog; 8-bit range.

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  IF requests instruction read; held until if_done
- if_addr  in  64  fetch address, 4-byte aligned
- if_done  out  1  one-cycle pulse: if_rdata/if_err valid
- if_rdata  out  32  fetched instruction
- if_err  out  1  valid with if_done; watchdog expired
- m_req  in  1  M stage requests access; held until m_done
- m_we  in  1  1 = store, 0 = load
- m_addr  in  64  data address
- m_wdata  in  64  store data
- m_wmask  in  8  byte-lane write strobes
- m_done  out  1  one-cycle pulse: m_rdata/m_err valid
- m_rdata  out  64  load data, raw 64-bit word (M stage aligns/extends)
- m_err  out  1  valid with m_done
- stall_if  out  1  if_req & ~if_done (combinational)
- stall_m  out  1  m_req & ~m_done (combinational)
- bus_valid  out  1  request valid to memory
- bus_ready  in  1  memory accepts request when bus_valid & bus_ready
- bus_we, bus_addr[64], bus_wdata[64], bus_wmask[8]  out  request fields, stable while bus_valid
- bus_resp_valid  in  1  read data / write ack
- bus_rdata  in  64  read data

Behaviour:
- Reset: async; state=IDLE, owner=IF, counter=0; every output register 0: bus_valid, bus_we, bus_addr, bus_wdata, bus_wmask, if_done, m_done, if_rdata, m_rdata, if_err, m_err.
- Reset mid-transaction aborts immediately; bus_valid drops at reset assertion; no done pulse is issued.
- States: IDLE, REQ, RESP, DONE.
- IDLE:
  - m_req=1: latch M fields into bus_* and set owner=M; next state REQ.
  - else if_req=1: latch if_addr, we=0, wmask=0, owner=IF; next state REQ.
  - Fixed priority M > IF; M holds the older instruction.
- REQ:
  - bus_valid=1.
  - bus_ready=1 at edge: next state RESP, bus_valid cleared, counter cleared.
  - bus_ready=0: stay in REQ; no timeout applies here.
- RESP:
  - bus_resp_valid=1 at edge: capture data into owner's rdata, err=0; next state DONE.
  - owner=IF: if_rdata = bus_addr[2] ? bus_rdata[63:32] : bus_rdata[31:0].
  - Write response: m_rdata is loaded with 0.
  - Otherwise counter++.
  - If TIMEOUT != 0 and counter == TIMEOUT-1 with no response: owner rdata=0, err=1; next state DONE.
  - bus_resp_valid takes precedence over timeout in the same cycle.
- DONE:
  - Owner's done=1 for exactly this cycle; next state IDLE.
  - No request is sampled in DONE, so a requester that is still high does not get a duplicate grant.
- Latency, zero-wait memory: request seen in IDLE cycle 0, REQ cycle 1, RESP cycle 2, done in cycle 3. Throughput is one access per 4 cycles.
- if_done and m_done are never high in the same cycle.
- rdata/err hold their last values until the next capture.
- bus_resp_valid outside RESP is ignored.
- Requester dropping req mid-transaction has no effect; the transaction completes and done still pulses.
- bus_* field changes are legal only in IDLE.

Decomposition:
- defines.v:
  - state encodings `ARB_IDLE/`ARB_REQ/`ARB_RESP/`ARB_DONE (2-bit).
  - `INST_BUS 31:0 and `MASK_BUS 7:0.
  - reuse `REG_BUS and `ZERO_WORD.
- Single module; the watchdog counter is small enough to inline, so no sub-module.

Test Plan:
- IF read, zero-wait bus, if_addr=0x8000_0004, bus_rdata=0x1111_2222_3333_4444 -> if_done in cycle 3, if_rdata=0x1111_2222; stall_if high cycles 0-2.
- m_req load and if_req together in IDLE -> M granted first (bus_addr=m_addr); m_done; one idle DONE cycle; IF granted next; done order M then IF.
- Store m_wmask=0x0F, m_wdata=0xDEAD_BEEF, bus_ready low 3 cycles -> bus_valid held 4 cycles with stable fields; write ack -> m_done, m_err=0, m_rdata=0.
- TIMEOUT=4, no bus_resp_valid -> m_done exactly 4 cycles after entering RESP, m_err=1, m_rdata=0; TIMEOUT=0 -> FSM stays in RESP indefinitely.
- rst asserted asynchronously while in REQ -> bus_valid and all outputs 0 before next edge, no done pulse; after release, a held if_req is re-served from IDLE.
- bus_resp_valid and timeout in the same cycle -> normal data captured, err=0.
